// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and alignment check for the data memory controller.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Flags requests whose size is illegal or whose address is not size-aligned.
  function automatic logic misalign(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: byte enables and replicated store data, plus load extraction and extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lo,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] ldata
);

  logic [4:0]        sh_amt;
  logic [DATA_W-1:0] shifted;

  assign sh_amt  = {lo, 3'b000};
  assign shifted = rword >> sh_amt;

  // Decode lanes from size and offset; misaligned cases are masked by the caller.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    ldata     = '0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << lo;
        wdata_rep = {4{wdata[7:0]}};
        ldata     = is_unsigned ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be        = 4'b0011 << lo;
        wdata_rep = {2{wdata[15:0]}};
        ldata     = is_unsigned ? {16'd0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        ldata     = rword;
      end
      default: begin
        be        = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data memory controller: optional post-reset clear, byte/half/word access, one-cycle response.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam state_t      RST_STATE = INIT_ZERO ? INIT : READY;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nx;
  logic [IDX_W-1:0]  cnt, cnt_nx;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lo;
  logic              accept;
  logic              err;
  logic [DATA_W-1:0] rword;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] ldata;

  assign idx       = req_addr[ADDR_W-1:2];
  assign lo        = req_addr[1:0];
  assign req_ready = (state == READY);
  assign init_done = (state == READY);
  assign accept    = req_valid && req_ready;
  assign err       = misalign(req_size, lo);
  assign rword     = mem[idx];

  dmem_lane_align u_align (
    .size        (req_size),
    .lo          (lo),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .rword       (rword),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .ldata       (ldata)
  );

  // State and clear-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: walk every word once in INIT, then stay in READY.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      INIT: begin
        cnt_nx = cnt + IDX_W'(1);
        if (cnt == IDX_W'(DEPTH - 1)) begin
          state_nx = READY;
          cnt_nx   = '0;
        end
      end
      READY: begin
        state_nx = READY;
      end
      default: begin
        state_nx = RST_STATE;
      end
    endcase
  end

  // Storage: no reset; cleared by INIT, otherwise written per enabled byte lane.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

  // Response register: pulse valid, hold data and error between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err   <= err;
        rsp_rdata <= (err || req_we) ? '0 : ldata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a 16-word memory.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int n_vec  = 0;
  int n_fail = 0;

  dmem_ctrl #(.ADDR_W(6), .INIT_ZERO(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [5:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // One isolated request; checks the response the cycle after acceptance, then that it drops.
  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [5:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err);
    drive(we, size, uns, addr, wdata);
    step();
    req_valid = 1'b0;
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rdata"}, rsp_rdata, exp_data);
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    step();
    chk({tag, ".drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".hold"}, rsp_rdata, exp_data);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".init_done"}, 32'(init_done), 32'd0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  // Clear must take exactly 16 cycles after reset release; INIT-time requests are ignored.
  task automatic check_clear(input string tag);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("%s.ready%0d", tag, k), 32'(req_ready), (k == 16) ? 32'd1 : 32'd0);
      chk($sformatf("%s.novalid%0d", tag, k), 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    step();
    step();
    check_reset_outputs("t1.rst");

    // Test 1: clear timing, with a store held during INIT that must not land.
    rst = 1'b0;
    drive(1'b1, 2'd2, 1'b0, 6'h3C, 32'hFFFF_FFFF);
    chk("t1.ready0", 32'(req_ready), 32'd0);
    check_clear("t1");
    req_valid = 1'b0;
    chk("t1.init_done", 32'(init_done), 32'd1);
    step();
    xact("t1.ld3c", 1'b0, 2'd2, 1'b0, 6'h3C, 32'd0, 32'h0000_0000, 1'b0);

    // Test 2: word store then byte loads.
    xact("t2.st", 1'b1, 2'd2, 1'b0, 6'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xact("t2.b0", 1'b0, 2'd0, 1'b0, 6'h10, 32'd0, 32'hFFFF_FFEF, 1'b0);
    xact("t2.b1", 1'b0, 2'd0, 1'b0, 6'h11, 32'd0, 32'hFFFF_FFBE, 1'b0);
    xact("t2.b2", 1'b0, 2'd0, 1'b0, 6'h12, 32'd0, 32'hFFFF_FFAD, 1'b0);
    xact("t2.b3", 1'b0, 2'd0, 1'b0, 6'h13, 32'd0, 32'hFFFF_FFDE, 1'b0);
    xact("t2.b3u", 1'b0, 2'd0, 1'b1, 6'h13, 32'd0, 32'h0000_00DE, 1'b0);
    xact("t2.w", 1'b0, 2'd2, 1'b0, 6'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);

    // Test 3: half store into upper lanes.
    xact("t3.stw", 1'b1, 2'd2, 1'b0, 6'h20, 32'hAAAA_AAAA, 32'h0, 1'b0);
    xact("t3.sth", 1'b1, 2'd1, 1'b0, 6'h22, 32'h5555_1234, 32'h0, 1'b0);
    xact("t3.ldw", 1'b0, 2'd2, 1'b0, 6'h20, 32'd0, 32'h1234_AAAA, 1'b0);
    xact("t3.ldh", 1'b0, 2'd1, 1'b0, 6'h20, 32'd0, 32'hFFFF_AAAA, 1'b0);
    xact("t3.ldhu", 1'b0, 2'd1, 1'b1, 6'h22, 32'd0, 32'h0000_1234, 1'b0);

    // Test 4: misaligned and illegal-size requests, memory untouched.
    xact("t4.ldw21", 1'b0, 2'd2, 1'b0, 6'h21, 32'd0, 32'h0, 1'b1);
    xact("t4.sth23", 1'b1, 2'd1, 1'b0, 6'h23, 32'h0000_FFFF, 32'h0, 1'b1);
    xact("t4.sz3", 1'b1, 2'd3, 1'b0, 6'h20, 32'h0000_0000, 32'h0, 1'b1);
    xact("t4.ldw", 1'b0, 2'd2, 1'b0, 6'h20, 32'd0, 32'h1234_AAAA, 1'b0);

    // Test 5: back-to-back store then load of the same byte.
    drive(1'b1, 2'd0, 1'b0, 6'h08, 32'hFFFF_FF55);
    step();
    chk("t5.v0", 32'(rsp_valid), 32'd1);
    chk("t5.d0", rsp_rdata, 32'd0);
    drive(1'b0, 2'd0, 1'b1, 6'h08, 32'd0);
    step();
    req_valid = 1'b0;
    chk("t5.v1", 32'(rsp_valid), 32'd1);
    chk("t5.d1", rsp_rdata, 32'h0000_0055);
    step();
    chk("t5.drop", 32'(rsp_valid), 32'd0);
    xact("t5.w", 1'b0, 2'd2, 1'b0, 6'h08, 32'd0, 32'h0000_0055, 1'b0);

    // Test 6: reset mid-traffic, then again at INIT cycle 5; clear reruns in full.
    drive(1'b0, 2'd2, 1'b0, 6'h10, 32'd0);
    step();
    chk("t6.pre", rsp_rdata, 32'hDEAD_BEEF);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("t6.async");
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("t6.mid", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1 check_reset_outputs("t6.rst2");
    step();
    check_reset_outputs("t6.rst2b");
    rst = 1'b0;
    check_clear("t6");
    xact("t6.ld10", 1'b0, 2'd2, 1'b0, 6'h10, 32'd0, 32'h0, 1'b0);
    xact("t6.ld3c", 1'b0, 2'd2, 1'b0, 6'h3C, 32'd0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width; memory depth is 2**(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter INIT_ZERO, default 1; 1 means memory is cleared after reset, 0 means no clear.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: request present.
REQ-005 SHALL have port req_ready, output, 1 bit: request accepted this cycle if req_valid is high.
REQ-006 SHALL have port req_we, input, 1 bit: 1 is store, 0 is load.
REQ-007 SHALL have port req_size, input, 2 bits: 0 byte, 1 half, 2 word, 3 illegal.
REQ-008 SHALL have port req_unsigned, input, 1 bit: load zero-extends if 1, sign-extends if 0.
REQ-009 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata, output, 32 bits: extended load data.
REQ-013 SHALL have port rsp_err, output, 1 bit: misaligned or illegal-size request.
REQ-014 SHALL have port init_done, output, 1 bit: clear complete and block usable.

Function
REQ-015 SHALL implement states INIT, READY; after reset, state is INIT if INIT_ZERO=1, else READY.
REQ-016 In INIT, SHALL write 0 to word index cnt each cycle, cnt counting 0..DEPTH-1; after writing DEPTH-1 it SHALL go to READY (DEPTH cycles total).
REQ-017 req_ready and init_done SHALL be 0 in INIT and 1 in READY; a request presented in INIT SHALL be ignored.
REQ-018 Acceptance is req_valid&&req_ready; SHALL sustain one accepted request per cycle with no bubbles.
REQ-019 Misalignment SHALL be half with addr[0]=1, word with addr[1:0]!=0, or size=3.
REQ-020 An erroneous request SHALL leave memory unchanged; its response SHALL have rsp_err=1 and rsp_rdata=0.
REQ-021 A legal store SHALL update only the addressed byte lanes, using byte enables from size and addr[1:0], at the accepting clock edge.
REQ-022 Store data SHALL come from req_wdata[7:0] for a byte, [15:0] for a half, and [31:0] for a word.
REQ-023 A legal load SHALL extract the addressed lanes and zero- or sign-extend them to 32 bits per req_unsigned.
REQ-024 Every accepted request SHALL produce exactly one response, with rsp_valid high for one cycle on the cycle after acceptance.
REQ-025 A store response SHALL have rsp_err=0 and rsp_rdata=0.
REQ-026 There is no response backpressure; the consumer SHALL always accept a response.
REQ-027 For a store at cycle N followed by a load of the same word at N+1, the load SHALL return the post-store data.
REQ-028 rsp_rdata and rsp_err SHALL hold their values when rsp_valid=0, and reset to 0.
REQ-029 Word index SHALL be req_addr[ADDR_W-1:2]; there are no out-of-range addresses.

Reset
REQ-030 While rst=1: req_ready=0, init_done=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0, state per REQ-015.
REQ-031 Reset asserted mid-INIT SHALL restart the clear from word 0.
REQ-032 Reset asserted mid-traffic SHALL drop any pending response; memory contents not yet cleared are undefined until INIT completes.
REQ-033 Memory array SHALL have no reset; only INIT clears it.

Structure
REQ-034 SHALL provide shared package dmem_pkg, containing the size encodings SZ_B=0, SZ_H=1, SZ_W=2, the state enum {INIT, READY}, and a misalign function.
REQ-035 SHALL have one combinational sub-module, dmem_lane_align, producing byte enables, replicated write data, and extended load data.
REQ-036 Storage SHALL be a DEPTH x 32 array written per byte lane with a synchronous read.

Verification
REQ-037 Test 1: with INIT_ZERO=1, ADDR_W=6, release reset -> req_ready=0 for 16 cycles, then 1; a word load at 0x3C returns 0x00000000.
REQ-038 Test 2: word store 0xDEADBEEF at 0x10, then byte loads at 0x10..0x13, signed -> 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE; unsigned at 0x13 -> 0x000000DE.
REQ-039 Test 3: half store 0x1234 at 0x22 over word 0xAAAAAAAA -> word load at 0x20 returns 0x1234AAAA; signed half load at 0x20 returns 0xFFFFAAAA.
REQ-040 Test 4: word load at 0x21, half store at 0x23, size=3 at 0x20 -> each rsp_err=1, rsp_rdata=0; memory unchanged.
REQ-041 Test 5: back-to-back store 0x55 byte at 0x08, then load byte at 0x08 the next cycle -> rsp_rdata=0x00000055 on the second response; rsp_valid stays high for 2 consecutive cycles.
REQ-042 Test 6: assert rst at INIT cycle 5, release -> full DEPTH-cycle clear reruns; outputs at reset values during rst.
